// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the AES byte-substitution datapath.
//   AES_BLOCK_W : width of one AES state in bits
//   AES_BYTES   : number of bytes in one AES state
//   MODE_FWD / MODE_INV : encoding of the substitution direction
//   state_t     : control FSM states of sub_bytes_lanes
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = 16;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sbox_lane.sv
// -----------------------------------------------------------------------------
// sbox_lane
// One byte of the AES S-box, purely combinational, forward or inverse.
// The table is not stored; it is computed from its algebraic definition
// (multiplicative inverse in GF(2^8) combined with the affine transform).
// Ports:
//   in_byte  : byte to substitute
//   inv      : mode select, MODE_FWD or MODE_INV
//   out_byte : substituted byte
// Parameter INV_EN = 0 forces forward mode; the inverse path then has a
// constant-false select and is pruned by synthesis.
// -----------------------------------------------------------------------------
module sbox_lane
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [7:0] in_byte,
    input  logic       inv,
    output logic [7:0] out_byte
);

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] acc;
        prod = 8'h00;
        acc  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ acc;
            end
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
        end
        return prod;
    endfunction

    // Inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] result;
        logic [7:0] sq;
        result = 8'h01;
        sq     = x;
        for (int i = 1; i < 8; i++) begin
            sq     = gf_mul(sq, sq);
            result = gf_mul(result, sq);
        end
        return result;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] a);
        return a ^ rotl8(a, 1) ^ rotl8(a, 2) ^ rotl8(a, 3) ^ rotl8(a, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] s);
        return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
    endfunction

    logic use_inv;

    always_comb begin
        use_inv = (inv == MODE_INV) && INV_EN;
        if (use_inv) begin
            out_byte = gf_inv(affine_inv(in_byte));
        end else begin
            out_byte = affine_fwd(gf_inv(in_byte));
        end
    end

endmodule

// File: rtl/sub_bytes_lanes.sv
// -----------------------------------------------------------------------------
// sub_bytes_lanes
// Applies SubBytes / InvSubBytes to a 128-bit AES state, LANES bytes per
// cycle, using a single working register that is updated in place.
// Parameters:
//   LANES  : S-box lanes per cycle (1, 2, 4, 8 or 16)
//   INV_EN : 1 builds the inverse path, 0 treats inverse requests as forward
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   in_valid / in_ready : input handshake, accepted only in IDLE
//   in_data, in_inv     : AES state (byte 0 in [127:120]) and mode
//   out_valid/out_ready : output handshake, result held in DONE
//   out_data            : working register (meaningful while out_valid)
//   busy                : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module sub_bytes_lanes
    import aes_pkg::*;
#(
    parameter int LANES  = 4,
    parameter bit INV_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    localparam int GROUPS  = AES_BYTES / LANES;
    localparam int CNT_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int GROUP_W = LANES * 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] work_q, work_d;
    logic                   mode_q, mode_d;

    logic [CNT_W-1:0]       grp_idx;
    logic [6:0]             grp_lsb;
    logic [GROUP_W-1:0]     grp_in;
    logic [GROUP_W-1:0]     grp_out;

    // Byte 0 sits in the top bits, so group cnt starts GROUPS-1-cnt groups
    // up from bit 0. The product never exceeds 128-GROUP_W, so 7 bits hold it.
    always_comb begin
        grp_idx = CNT_LAST - cnt_q;
        grp_lsb = 7'(grp_idx) * 7'(GROUP_W);
        grp_in  = work_q[grp_lsb +: GROUP_W];
    end

    // Lane i handles byte cnt*LANES+i, the i-th byte from the top of the group.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbox_lane #(
            .INV_EN (INV_EN)
        ) u_sbox (
            .in_byte  (grp_in[GROUP_W-1-8*i -: 8]),
            .inv      (mode_q),
            .out_byte (grp_out[GROUP_W-1-8*i -: 8])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    mode_d  = in_inv & INV_EN;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d[grp_lsb +: GROUP_W] = grp_out;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            mode_q  <= MODE_FWD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = work_q;

endmodule

// File: tb/tb_sub_bytes_lanes.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_lanes
// Drives four configurations of sub_bytes_lanes (LANES 4/1/16/2, the last
// with the inverse path disabled) plus a chained pair of sbox_lane instances,
// and compares against a table-driven AES S-box reference.
// -----------------------------------------------------------------------------
module tb_sub_bytes_lanes;

    localparam int NDUT = 4;
    localparam int LANES_CFG [NDUT] = '{4, 1, 16, 2};
    localparam bit INV_CFG   [NDUT] = '{1'b1, 1'b1, 1'b1, 1'b0};

    // FIPS-197 forward S-box, row = high nibble.
    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic         clk;
    logic         rst_n;
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic [127:0] in_data   [NDUT];
    logic         in_inv    [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [127:0] out_data  [NDUT];
    logic         busy      [NDUT];

    logic [7:0]   lane_x, lane_y, lane_z;
    logic [7:0]   inv_tab [256];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sub_bytes_lanes #(.LANES(4), .INV_EN(1'b1)) u_dut_l4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_inv(in_inv[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
    );

    sub_bytes_lanes #(.LANES(1), .INV_EN(1'b1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_inv(in_inv[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
    );

    sub_bytes_lanes #(.LANES(16), .INV_EN(1'b1)) u_dut_l16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_inv(in_inv[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
    );

    sub_bytes_lanes #(.LANES(2), .INV_EN(1'b0)) u_dut_l2_noinv (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]), .in_inv(in_inv[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]), .busy(busy[3])
    );

    sbox_lane #(.INV_EN(1'b1)) u_lane_fwd (.in_byte(lane_x), .inv(1'b0), .out_byte(lane_y));
    sbox_lane #(.INV_EN(1'b1)) u_lane_inv (.in_byte(lane_y), .inv(1'b1), .out_byte(lane_z));

    // Whole-state reference: every byte independently looked up in the table.
    function automatic logic [127:0] refSub(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = d[127-8*k -: 8];
            r[127-8*k -: 8] = inv ? inv_tab[b] : SBOX[b];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Called at a negedge after the accept edge; counts edges until out_valid.
    task automatic waitResult(input int idx, output logic [127:0] got, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid[idx] && lat < 40);
        got = out_data[idx];
    endtask

    task automatic releaseResult(input int idx);
        out_ready[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[idx] = 1'b0;
    endtask

    // One full job on DUT idx; inputs are scrambled right after accept.
    task automatic applyStimulus(input int idx, input logic [127:0] data, input logic inv, input string tag);
        logic [127:0] got;
        logic [127:0] exp_data;
        int           lat;
        exp_data       = refSub(data, inv & INV_CFG[idx]);
        in_valid[idx]  = 1'b1;
        in_data[idx]   = data;
        in_inv[idx]    = inv;
        @(posedge clk);
        @(negedge clk);
        in_valid[idx]  = 1'b0;
        in_data[idx]   = {$urandom, $urandom, $urandom, $urandom};
        in_inv[idx]    = ~inv;
        waitResult(idx, got, lat);
        checkOutput({tag, "_lat"}, 128'(lat), 128'(16 / LANES_CFG[idx]));
        checkOutput({tag, "_data"}, got, exp_data);
        releaseResult(idx);
        checkOutput({tag, "_idle"}, 128'(in_ready[idx]), 128'(1));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] got, d1, d2, hold;
        int           lat, seen, idx;
        logic         inv;

        for (int x = 0; x < 256; x++) begin
            inv_tab[SBOX[x]] = 8'(x);
        end
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_inv[i]    = 1'b0;
            out_ready[i] = 1'b0;
        end
        lane_x = 8'h00;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("rst%0d_in_ready", i), 128'(in_ready[i]), 128'(1));
            checkOutput($sformatf("rst%0d_out_valid", i), 128'(out_valid[i]), 128'(0));
            checkOutput($sformatf("rst%0d_busy", i), 128'(busy[i]), 128'(0));
            checkOutput($sformatf("rst%0d_out_data", i), out_data[i], 128'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, "fips_fwd");
        checkOutput("fips_fwd_const", refSub(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0),
                    128'hd42711aee0bf98f1b8b45de51e415230);
        applyStimulus(0, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, "fips_inv");
        applyStimulus(1, 128'h0, 1'b0, "l1_zero");
        applyStimulus(2, 128'h0, 1'b0, "l16_zero");
        applyStimulus(3, 128'h0, 1'b1, "noinv_zero");
        checkOutput("zero_const", refSub(128'h0, 1'b0), {16{8'h63}});

        for (int n = 0; n < 24; n++) begin
            idx = int'($urandom_range(0, NDUT - 1));
            inv = 1'($urandom_range(0, 1));
            applyStimulus(idx, {$urandom, $urandom, $urandom, $urandom}, inv, $sformatf("rnd%0d_dut%0d", n, idx));
        end

        // Back-pressure: hold DONE for 10 cycles with a competing request.
        d1 = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        hold = refSub(d1, 1'b0);
        in_valid[0] = 1'b1;
        in_data[0]  = d1;
        in_inv[0]   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        waitResult(0, got, lat);
        checkOutput("bp_data", got, hold);
        for (int c = 0; c < 10; c++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = d2;
            in_inv[0]   = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_hold_data", out_data[0], hold);
            checkOutput("bp_hold_in_ready", 128'(in_ready[0]), 128'(0));
            checkOutput("bp_hold_out_valid", 128'(out_valid[0]), 128'(1));
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;
        checkOutput("bp_release_idle", 128'(in_ready[0]), 128'(1));
        checkOutput("bp_release_valid", 128'(out_valid[0]), 128'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        checkOutput("bp_next_accept", 128'(busy[0]), 128'(1));
        waitResult(0, got, lat);
        checkOutput("bp_next_lat", 128'(lat), 128'(4));
        checkOutput("bp_next_data", got, refSub(d2, 1'b1));
        releaseResult(0);

        // Abort a LANES=4 job while cnt is 2.
        in_valid[0] = 1'b1;
        in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
        in_inv[0]   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_in_ready", 128'(in_ready[0]), 128'(1));
        checkOutput("abort_busy", 128'(busy[0]), 128'(0));
        checkOutput("abort_out_data", out_data[0], 128'(0));
        checkOutput("abort_out_valid", 128'(out_valid[0]), 128'(0));
        rst_n = 1'b1;
        seen  = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        checkOutput("abort_no_valid", 128'(seen), 128'(0));
        applyStimulus(0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, "after_abort");

        // Exhaustive single-lane forward table and round trip.
        for (int x = 0; x < 256; x++) begin
            lane_x = 8'(x);
            #1;
            checkOutput($sformatf("lane_fwd_%02h", x), 128'(lane_y), 128'(SBOX[x]));
            checkOutput($sformatf("lane_rt_%02h", x), 128'(lane_z), 128'(x));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
